// File: rtl/axis_pkt_gen.sv
// axis_pkt_gen: AXI-Stream burst generator emitting incrementing-data packets
// separated by a fixed number of idle gap cycles.
module axis_pkt_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [7:0]            pkt_len,
    input  logic [7:0]            num_pkts,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic [DATA_WIDTH-1:0] output_tdata,
    output logic                  output_tvalid,
    input  logic                  output_tready,
    output logic                  output_tlast,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            pkt_count
);
    localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t                state_q, state_d;
    logic [7:0]            len_q, len_d, npk_q, npk_d, beat_q, beat_d, cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic                  done_q, done_d;
    logic                  last, xfer;

    // tvalid comes straight from the state register, so it never depends on tready
    assign output_tvalid = state_q == SEND;
    assign last          = beat_q == len_q - 8'd1;
    assign output_tlast  = output_tvalid && last;
    assign output_tdata  = data_q;
    assign xfer          = output_tvalid && output_tready;
    assign busy          = state_q != IDLE;
    assign done          = done_q;
    assign pkt_count     = cnt_q;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        npk_d   = npk_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        gap_d   = gap_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                len_d  = pkt_len == 8'd0 ? 8'd1 : pkt_len;
                npk_d  = num_pkts;
                data_d = seed;
                cnt_d  = 8'd0;
                beat_d = 8'd0;
                if (num_pkts == 8'd0) done_d = 1'b1;
                else state_d = SEND;
            end
            SEND: if (xfer) begin
                data_d = data_q + 1'b1;
                beat_d = last ? 8'd0 : beat_q + 8'd1;
                if (last) begin
                    cnt_d = cnt_q + 8'd1;
                    gap_d = '0;
                    if (cnt_q + 8'd1 == npk_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = GAP_CYCLES == 0 ? SEND : GAP;
                    end
                end
            end
            GAP: begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GW'(GAP_CYCLES - 1)) state_d = SEND;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            npk_q   <= '0;
            beat_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            gap_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            npk_q   <= npk_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            gap_q   <= gap_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_axis_pkt_gen.sv
// tb_axis_pkt_gen: randomized self-checking bench; expected beats come from a
// queue built from seed/length/count arithmetic.
module tb_axis_pkt_gen;
    localparam int GAP = 2;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } beat_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] pkt_len = '0;
    logic [7:0] num_pkts = '0;
    logic [7:0] seed = '0;
    logic [7:0] output_tdata;
    logic       output_tvalid;
    logic       output_tready = 1'b0;
    logic       output_tlast;
    logic       busy;
    logic       done;
    logic [7:0] pkt_count;

    int total = 0;
    int bad = 0;

    axis_pkt_gen #(.DATA_WIDTH(8), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .pkt_len(pkt_len),
        .num_pkts(num_pkts), .seed(seed), .output_tdata(output_tdata),
        .output_tvalid(output_tvalid), .output_tready(output_tready),
        .output_tlast(output_tlast), .busy(busy), .done(done), .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    // Called at a negedge; returns at the negedge where done must be pulsing.
    // mode: 0 ready always, 1 ready toggles, 2 ready random.
    // restart_at: cycle at which a conflicting start is injected (-1 none).
    task automatic run_burst(input logic [7:0] s, input logic [7:0] len,
                             input logic [7:0] n, input int mode, input int restart_at);
        beat_t q[$];
        int eff, pk, gap, cyc;
        bit in_gap;
        beat_t b;
        eff = len == 0 ? 1 : int'(len);
        for (int i = 0; i < int'(n) * eff; i++) begin
            b.d = s + 8'(i);
            b.l = (i % eff) == eff - 1;
            q.push_back(b);
        end
        start = 1'b1; pkt_len = len; num_pkts = n; seed = s;
        output_tready = mode == 2 ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        start = 1'b0;
        pk = 0; gap = 0; in_gap = 0; cyc = 0;
        while (q.size() > 0 && cyc < 3000) begin
            if (cyc == restart_at) begin
                start = 1'b1; pkt_len = len + 8'd3; num_pkts = n + 8'd1; seed = s ^ 8'hA5;
            end else begin
                start = 1'b0;
            end
            total++;
            if (output_tvalid) begin
                if (in_gap) begin
                    total++;
                    if (gap != GAP) begin
                        bad++;
                        $display("FAIL gap_len: got %0d idle cycles want %0d", gap, GAP);
                    end
                    in_gap = 0;
                end
                if (output_tdata !== q[0].d || output_tlast !== q[0].l) begin
                    bad++;
                    $display("FAIL beat: got d=%h l=%b want d=%h l=%b", output_tdata, output_tlast, q[0].d, q[0].l);
                end
            end else if (in_gap) begin
                gap++;
            end else begin
                bad++;
                $display("FAIL tvalid: got 0 want 1 (data %h pending)", q[0].d);
            end
            total++;
            if (busy !== 1'b1 || done !== 1'b0 || pkt_count !== 8'(pk)) begin
                bad++;
                $display("FAIL status: got busy=%b done=%b cnt=%0d want busy=1 done=0 cnt=%0d", busy, done, pkt_count, pk);
            end
            if (output_tvalid && output_tready) begin
                b = q.pop_front();
                if (b.l) begin
                    pk++;
                    in_gap = 1;
                    gap = 0;
                end
            end
            @(negedge clk);
            cyc++;
            output_tready = mode == 0 ? 1'b1 : mode == 1 ? ~output_tready : 1'($urandom_range(0, 1));
        end
        start = 1'b0;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL timeout: got %0d beats outstanding want 0", q.size());
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || output_tvalid !== 1'b0 || pkt_count !== n) begin
            bad++;
            $display("FAIL end: got done=%b busy=%b tvalid=%b cnt=%0d want done=1 busy=0 tvalid=0 cnt=%0d",
                     done, busy, output_tvalid, pkt_count, n);
        end
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (output_tvalid !== 1'b0 || output_tlast !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            output_tdata !== 8'h00 || pkt_count !== 8'h00) begin
            bad++;
            $display("FAIL reset_state: got v=%b l=%b b=%b d=%b data=%h cnt=%0d want all 0",
                     output_tvalid, output_tlast, busy, done, output_tdata, pkt_count);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_burst(8'h10, 8'd4, 8'd2, 0, -1);
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse: got %b want 0 one cycle after", done);
        end
    endtask

    task automatic test_backpressure();
        run_burst(8'h10, 8'd4, 8'd2, 1, -1);
        @(negedge clk);
    endtask

    task automatic test_wrap();
        run_burst(8'hFE, 8'd3, 8'd1, 0, -1);
        @(negedge clk);
    endtask

    task automatic test_zero_cases();
        run_burst(8'h33, 8'd5, 8'd0, 0, -1);
        @(negedge clk);
        total++;
        if (done !== 1'b0 || output_tvalid !== 1'b0) begin
            bad++;
            $display("FAIL zero_pkts: got done=%b tvalid=%b want 0 0", done, output_tvalid);
        end
        run_burst(8'h40, 8'd0, 8'd2, 0, -1);
        @(negedge clk);
    endtask

    task automatic test_restart_ignored();
        run_burst(8'h20, 8'd4, 8'd2, 0, 3);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        run_burst(8'h70, 8'd2, 8'd2, 0, -1);
        run_burst(8'h80, 8'd3, 8'd1, 1, -1);
        @(negedge clk);
    endtask

    task automatic test_midpacket_reset();
        int cyc;
        start = 1'b1; pkt_len = 8'd4; num_pkts = 8'd1; seed = 8'h50; output_tready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(output_tvalid && output_tdata == 8'h52) && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (cyc >= 20) begin
            bad++;
            $display("FAIL reach_beat2: got no beat 52 want it within 20 cycles");
        end
        reset_n = 1'b0;
        #1;
        total++;
        if (output_tvalid !== 1'b0 || output_tlast !== 1'b0 || busy !== 1'b0 || output_tdata !== 8'h00 || pkt_count !== 8'h00) begin
            bad++;
            $display("FAIL abort: got v=%b l=%b b=%b data=%h cnt=%0d want all 0",
                     output_tvalid, output_tlast, busy, output_tdata, pkt_count);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (output_tvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                bad++;
                $display("FAIL post_reset_idle: got v=%b b=%b d=%b want 0 0 0", output_tvalid, busy, done);
            end
        end
        run_burst(8'h50, 8'd4, 8'd1, 0, -1);
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            run_burst(8'($urandom), 8'($urandom_range(0, 5)), 8'($urandom_range(0, 3)),
                      int'($urandom_range(0, 2)), $urandom_range(0, 1) == 1 ? int'($urandom_range(0, 8)) : -1);
            for (int k = $urandom_range(0, 2); k > 0; k--) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero_cases();
        test_restart_ignored();
        test_back_to_back();
        test_midpacket_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
